// File: rtl/video_fbuf_swap_ctrl_if.sv
// Bundle of CSR, vsync, write/read DMA and status signals for the
// frame-buffer swap controller. Optional stats under FBUF_SWAP_STAT_EN.
interface video_fbuf_swap_ctrl_if #(
  parameter int AW = 19
`ifdef FBUF_SWAP_STAT_EN
  , parameter int SW = 16
`endif
);
  logic          iDmaEn;
  logic [AW-1:0] iFbufAdrs1;
  logic [AW-1:0] iFbufAdrs2;
  logic [AW-1:0] iFbufLen;
  logic          iVsyncStart;
  logic          oWrDmaReq;
  logic [AW-1:0] oWrDmaAdrs;
  logic [AW-1:0] oWrDmaLen;
  logic          iWrDmaAck;
  logic          iWrDmaDone;
  logic          oRdDmaReq;
  logic [AW-1:0] oRdDmaAdrs;
  logic [AW-1:0] oRdDmaLen;
  logic          iRdDmaAck;
  logic          iRdDmaDone;
  logic          oFrontSel;
  logic          oFrameRepeat;
  logic          oRdOverrun;
  logic          oBusy;
`ifdef FBUF_SWAP_STAT_EN
  logic [SW-1:0] oSwapCnt;
  logic [SW-1:0] oRepeatCnt;
`endif

  modport master (
    input  iDmaEn, iFbufAdrs1, iFbufAdrs2,
    input  iFbufLen, iVsyncStart,
    input  iWrDmaAck, iWrDmaDone,
    input  iRdDmaAck, iRdDmaDone,
    output oWrDmaReq, oWrDmaAdrs, oWrDmaLen,
    output oRdDmaReq, oRdDmaAdrs, oRdDmaLen,
    output oFrontSel, oFrameRepeat,
    output oRdOverrun, oBusy
`ifdef FBUF_SWAP_STAT_EN
    , output oSwapCnt, oRepeatCnt
`endif
  );

  modport slave (
    output iDmaEn, iFbufAdrs1, iFbufAdrs2,
    output iFbufLen, iVsyncStart,
    output iWrDmaAck, iWrDmaDone,
    output iRdDmaAck, iRdDmaDone,
    input  oWrDmaReq, oWrDmaAdrs, oWrDmaLen,
    input  oRdDmaReq, oRdDmaAdrs, oRdDmaLen,
    input  oFrontSel, oFrameRepeat,
    input  oRdOverrun, oBusy
`ifdef FBUF_SWAP_STAT_EN
    , input oSwapCnt, oRepeatCnt
`endif
  );
endinterface

// File: rtl/video_fbuf_swap_ctrl.sv
// Ping-pong frame-buffer scheduler: writes the back buffer, scans out the
// front buffer, swaps only at vsync once the back write is complete.
// Ports: iSysClk, iSysRst (sync, active-high), bus (master modport).
// Optional FBUF_SWAP_STAT_EN adds saturating swap/repeat counters.
module video_fbuf_swap_ctrl #(
  parameter int pMemAdrsWidth = 19
`ifdef FBUF_SWAP_STAT_EN
  , parameter int pStatWidth = 16
`endif
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  video_fbuf_swap_ctrl_if.master bus
);
  localparam int AW = pMemAdrsWidth;

  typedef enum logic [1:0] {
    WS_IDLE, WS_REQ, WS_BUSY, WS_HOLD
  } ws_t;

  ws_t           r_state;
  logic          r_front;
  logic          r_wr_req;
  logic [AW-1:0] r_wr_adrs;
  logic [AW-1:0] r_wr_len;
  logic          r_rd_req;
  logic          r_rd_busy;
  logic [AW-1:0] r_rd_adrs;
  logic [AW-1:0] r_rd_len;
  logic          r_repeat;
  logic          r_overrun;

  logic          w_busy_done;
  logic          w_swap;
  logic          w_repeat;
  logic          w_front_nxt;
  logic          w_wr_issue;
  logic          w_rd_issue;
  logic [AW-1:0] w_back_adrs;
  logic [AW-1:0] w_front_adrs;

  // A done arriving with vsync counts first, so that frame still swaps.
  assign w_busy_done = (r_state == WS_BUSY) & bus.iWrDmaDone;
  assign w_swap = bus.iVsyncStart &
                  ((r_state == WS_HOLD) | w_busy_done);
  assign w_repeat = bus.iVsyncStart &
                    ((r_state == WS_REQ) |
                     ((r_state == WS_BUSY) & ~bus.iWrDmaDone));
  assign w_front_nxt = r_front ^ w_swap;
  // Addresses follow the post-swap front selection.
  assign w_back_adrs  = w_front_nxt ? bus.iFbufAdrs1
                                    : bus.iFbufAdrs2;
  assign w_front_adrs = w_front_nxt ? bus.iFbufAdrs2
                                    : bus.iFbufAdrs1;
  assign w_wr_issue = bus.iDmaEn &
                      ((r_state == WS_IDLE) | w_swap);
  assign w_rd_issue = bus.iVsyncStart & bus.iDmaEn &
                      ~r_rd_busy;

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_state   <= WS_IDLE;
      r_front   <= 1'b0;
      r_wr_req  <= 1'b0;
      r_wr_adrs <= '0;
      r_wr_len  <= '0;
      r_rd_req  <= 1'b0;
      r_rd_busy <= 1'b0;
      r_rd_adrs <= '0;
      r_rd_len  <= '0;
      r_repeat  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_front   <= w_front_nxt;
      r_repeat  <= w_repeat;
      r_overrun <= bus.iVsyncStart & r_rd_busy;

      if (w_wr_issue) begin
        r_state   <= WS_REQ;
        r_wr_req  <= 1'b1;
        r_wr_adrs <= w_back_adrs;
        r_wr_len  <= bus.iFbufLen;
      end else begin
        unique case (r_state)
          WS_IDLE: ;
          WS_REQ: begin
            // Ack wins over a same-cycle disable: job was accepted.
            if (bus.iWrDmaAck) begin
              r_wr_req <= 1'b0;
              r_state  <= WS_BUSY;
            end else if (!bus.iDmaEn) begin
              r_wr_req <= 1'b0;
              r_state  <= WS_IDLE;
            end
          end
          WS_BUSY: begin
            if (bus.iWrDmaDone)
              r_state <= bus.iVsyncStart ? WS_IDLE
                                         : WS_HOLD;
          end
          WS_HOLD: begin
            if (bus.iVsyncStart) r_state <= WS_IDLE;
          end
          default: r_state <= WS_IDLE;
        endcase
      end

      if (w_rd_issue) begin
        r_rd_req  <= 1'b1;
        r_rd_busy <= 1'b1;
        r_rd_adrs <= w_front_adrs;
        r_rd_len  <= bus.iFbufLen;
      end else if (r_rd_req) begin
        if (bus.iRdDmaAck) begin
          r_rd_req <= 1'b0;
        end else if (!bus.iDmaEn) begin
          r_rd_req  <= 1'b0;
          r_rd_busy <= 1'b0;
        end
      end else if (r_rd_busy && bus.iRdDmaDone) begin
        r_rd_busy <= 1'b0;
      end
    end
  end

  assign bus.oWrDmaReq    = r_wr_req;
  assign bus.oWrDmaAdrs   = r_wr_adrs;
  assign bus.oWrDmaLen    = r_wr_len;
  assign bus.oRdDmaReq    = r_rd_req;
  assign bus.oRdDmaAdrs   = r_rd_adrs;
  assign bus.oRdDmaLen    = r_rd_len;
  assign bus.oFrontSel    = r_front;
  assign bus.oFrameRepeat = r_repeat;
  assign bus.oRdOverrun   = r_overrun;
  assign bus.oBusy = r_wr_req | r_rd_req |
                     (r_state == WS_BUSY) | r_rd_busy;

`ifdef FBUF_SWAP_STAT_EN
  logic [pStatWidth-1:0] r_swap_cnt;
  logic [pStatWidth-1:0] r_rep_cnt;

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      r_swap_cnt <= '0;
      r_rep_cnt  <= '0;
    end else begin
      if (w_swap && !(&r_swap_cnt))
        r_swap_cnt <= r_swap_cnt + 1'b1;
      if (w_repeat && !(&r_rep_cnt))
        r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign bus.oSwapCnt   = r_swap_cnt;
  assign bus.oRepeatCnt = r_rep_cnt;
`endif
endmodule

// File: tb/tb_video_fbuf_swap_ctrl.sv
// Bench for video_fbuf_swap_ctrl: scenario tasks drive stimulus,
// expected DMA jobs are queued and popped when a request appears.
module tb_video_fbuf_swap_ctrl;
  localparam int AW = 19;
  localparam logic [AW-1:0] A1  = 19'd0;
  localparam logic [AW-1:0] A2  = 19'd130560;
  localparam logic [AW-1:0] LEN = 19'd130559;

  typedef struct packed {
    logic [AW-1:0] adrs;
    logic [AW-1:0] len;
  } job_t;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;
  int   exp_swaps;
  int   exp_reps;
  job_t wr_q[$];
  job_t rd_q[$];
  job_t e;

  video_fbuf_swap_ctrl_if #(.AW(AW)) bus ();

  video_fbuf_swap_ctrl #(.pMemAdrsWidth(AW)) dut (
    .iSysClk (clk),
    .iSysRst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_run++;
    if ({bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy, bus.oFrontSel,
         bus.oFrameRepeat, bus.oRdOverrun} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 000000",
        {bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy, bus.oFrontSel,
         bus.oFrameRepeat, bus.oRdOverrun});
    end
    n_run++;
    if ({bus.oWrDmaAdrs, bus.oWrDmaLen, bus.oRdDmaAdrs,
         bus.oRdDmaLen} !== '0) begin
      n_fail++;
      $display("FAIL reset_adrs: got %0d %0d %0d %0d exp all 0",
        bus.oWrDmaAdrs, bus.oWrDmaLen, bus.oRdDmaAdrs, bus.oRdDmaLen);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_write();
    bus.iFbufAdrs1 = A1;
    bus.iFbufAdrs2 = A2;
    bus.iFbufLen   = LEN;
    bus.iDmaEn     = 1'b1;
    wr_q.push_back({A2, LEN});
    for (int k = 0; k < 8 && bus.oWrDmaReq !== 1'b1; k++) tick();
    n_run++;
    if (bus.oWrDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL first_wr_req: got %b exp 1", bus.oWrDmaReq);
    end else begin
      e = wr_q.pop_front();
      n_run++;
      if ({bus.oWrDmaAdrs, bus.oWrDmaLen} !== e) begin
        n_fail++;
        $display("FAIL first_wr_job: got %0d/%0d exp %0d/%0d",
          bus.oWrDmaAdrs, bus.oWrDmaLen, e.adrs, e.len);
      end
    end
    n_run++;
    if (bus.oFrontSel !== 1'b0) begin
      n_fail++;
      $display("FAIL first_front: got %b exp 0", bus.oFrontSel);
    end
    bus.iFbufAdrs2 = 19'd777;
    bus.iFbufLen   = 19'd5;
    tick();
    tick();
    n_run++;
    if (bus.oWrDmaReq !== 1'b1 || bus.oWrDmaAdrs !== A2 ||
        bus.oWrDmaLen !== LEN) begin
      n_fail++;
      $display("FAIL wr_hold: got req %b %0d/%0d exp 1 %0d/%0d",
        bus.oWrDmaReq, bus.oWrDmaAdrs, bus.oWrDmaLen, A2, LEN);
    end
    bus.iFbufAdrs2 = A2;
    bus.iFbufLen   = LEN;
    bus.iWrDmaAck  = 1'b1;
    tick();
    bus.iWrDmaAck  = 1'b0;
    n_run++;
    if (bus.oWrDmaReq !== 1'b0 || bus.oBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack: got req %b busy %b exp 0 1",
        bus.oWrDmaReq, bus.oBusy);
    end
  endtask

  task automatic test_swap();
    bus.iWrDmaDone = 1'b1;
    tick();
    bus.iWrDmaDone = 1'b0;
    rd_q.push_back({A2, LEN});
    wr_q.push_back({A1, LEN});
    bus.iVsyncStart = 1'b1;
    exp_swaps++;
    tick();
    bus.iVsyncStart = 1'b0;
    n_run++;
    if (bus.oFrontSel !== 1'b1 || bus.oFrameRepeat !== 1'b0) begin
      n_fail++;
      $display("FAIL swap_front: got sel %b rep %b exp 1 0",
        bus.oFrontSel, bus.oFrameRepeat);
    end
    n_run++;
    if (bus.oRdDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_rd_req: got %b exp 1", bus.oRdDmaReq);
    end else begin
      e = rd_q.pop_front();
      n_run++;
      if ({bus.oRdDmaAdrs, bus.oRdDmaLen} !== e) begin
        n_fail++;
        $display("FAIL swap_rd_job: got %0d/%0d exp %0d/%0d",
          bus.oRdDmaAdrs, bus.oRdDmaLen, e.adrs, e.len);
      end
    end
    n_run++;
    if (bus.oWrDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_wr_req: got %b exp 1", bus.oWrDmaReq);
    end else begin
      e = wr_q.pop_front();
      n_run++;
      if ({bus.oWrDmaAdrs, bus.oWrDmaLen} !== e) begin
        n_fail++;
        $display("FAIL swap_wr_job: got %0d/%0d exp %0d/%0d",
          bus.oWrDmaAdrs, bus.oWrDmaLen, e.adrs, e.len);
      end
    end
    bus.iWrDmaAck = 1'b1;
    bus.iRdDmaAck = 1'b1;
    tick();
    bus.iWrDmaAck = 1'b0;
    bus.iRdDmaAck = 1'b0;
    n_run++;
    if ({bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy} !== 3'b001) begin
      n_fail++;
      $display("FAIL swap_acks: got %b exp 001",
        {bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy});
    end
  endtask

  task automatic test_repeat();
    bus.iRdDmaDone = 1'b1;
    tick();
    bus.iRdDmaDone = 1'b0;
    rd_q.push_back({A2, LEN});
    bus.iVsyncStart = 1'b1;
    exp_reps++;
    tick();
    bus.iVsyncStart = 1'b0;
    n_run++;
    if (bus.oFrameRepeat !== 1'b1 || bus.oFrontSel !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_pulse: got rep %b sel %b exp 1 1",
        bus.oFrameRepeat, bus.oFrontSel);
    end
    n_run++;
    if (bus.oRdDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_rd_req: got %b exp 1", bus.oRdDmaReq);
    end else begin
      e = rd_q.pop_front();
      n_run++;
      if ({bus.oRdDmaAdrs, bus.oRdDmaLen} !== e) begin
        n_fail++;
        $display("FAIL repeat_rd_job: got %0d/%0d exp %0d/%0d",
          bus.oRdDmaAdrs, bus.oRdDmaLen, e.adrs, e.len);
      end
    end
    bus.iRdDmaAck = 1'b1;
    tick();
    bus.iRdDmaAck = 1'b0;
    n_run++;
    if (bus.oFrameRepeat !== 1'b0) begin
      n_fail++;
      $display("FAIL repeat_width: got %b exp 0", bus.oFrameRepeat);
    end
  endtask

  task automatic test_same_cycle();
    bus.iRdDmaDone = 1'b1;
    tick();
    bus.iRdDmaDone = 1'b0;
    wr_q.push_back({A2, LEN});
    rd_q.push_back({A1, LEN});
    bus.iWrDmaDone  = 1'b1;
    bus.iVsyncStart = 1'b1;
    exp_swaps++;
    tick();
    bus.iWrDmaDone  = 1'b0;
    bus.iVsyncStart = 1'b0;
    n_run++;
    if (bus.oFrontSel !== 1'b0 || bus.oFrameRepeat !== 1'b0) begin
      n_fail++;
      $display("FAIL same_swap: got sel %b rep %b exp 0 0",
        bus.oFrontSel, bus.oFrameRepeat);
    end
    n_run++;
    if (bus.oWrDmaReq !== 1'b1 || bus.oRdDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL same_reqs: got wr %b rd %b exp 1 1",
        bus.oWrDmaReq, bus.oRdDmaReq);
    end else begin
      e = wr_q.pop_front();
      n_run++;
      if ({bus.oWrDmaAdrs, bus.oWrDmaLen} !== e) begin
        n_fail++;
        $display("FAIL same_wr_job: got %0d/%0d exp %0d/%0d",
          bus.oWrDmaAdrs, bus.oWrDmaLen, e.adrs, e.len);
      end
      e = rd_q.pop_front();
      n_run++;
      if ({bus.oRdDmaAdrs, bus.oRdDmaLen} !== e) begin
        n_fail++;
        $display("FAIL same_rd_job: got %0d/%0d exp %0d/%0d",
          bus.oRdDmaAdrs, bus.oRdDmaLen, e.adrs, e.len);
      end
    end
    bus.iWrDmaAck = 1'b1;
    bus.iRdDmaAck = 1'b1;
    tick();
    bus.iWrDmaAck = 1'b0;
    bus.iRdDmaAck = 1'b0;
  endtask

  task automatic test_overrun();
    for (int v = 0; v < 2; v++) begin
      bus.iVsyncStart = 1'b1;
      exp_reps++;
      tick();
      bus.iVsyncStart = 1'b0;
      n_run++;
      if ({bus.oRdOverrun, bus.oRdDmaReq, bus.oFrameRepeat,
           bus.oFrontSel} !== 4'b1010) begin
        n_fail++;
        $display("FAIL overrun_%0d: got ovr/rd/rep/sel %b exp 1010",
          v, {bus.oRdOverrun, bus.oRdDmaReq, bus.oFrameRepeat,
              bus.oFrontSel});
      end
      tick();
    end
  endtask

  task automatic test_dma_disable();
    bus.iWrDmaDone = 1'b1;
    tick();
    bus.iWrDmaDone = 1'b0;
    bus.iRdDmaDone = 1'b1;
    tick();
    bus.iRdDmaDone = 1'b0;
    wr_q.push_back({A1, LEN});
    rd_q.push_back({A2, LEN});
    bus.iVsyncStart = 1'b1;
    exp_swaps++;
    tick();
    bus.iVsyncStart = 1'b0;
    n_run++;
    if (bus.oWrDmaReq !== 1'b1 || bus.oRdDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL dis_reqs: got wr %b rd %b exp 1 1",
        bus.oWrDmaReq, bus.oRdDmaReq);
    end else begin
      e = wr_q.pop_front();
      n_run++;
      if ({bus.oWrDmaAdrs, bus.oWrDmaLen} !== e) begin
        n_fail++;
        $display("FAIL dis_wr_job: got %0d/%0d exp %0d/%0d",
          bus.oWrDmaAdrs, bus.oWrDmaLen, e.adrs, e.len);
      end
      e = rd_q.pop_front();
      n_run++;
      if ({bus.oRdDmaAdrs, bus.oRdDmaLen} !== e) begin
        n_fail++;
        $display("FAIL dis_rd_job: got %0d/%0d exp %0d/%0d",
          bus.oRdDmaAdrs, bus.oRdDmaLen, e.adrs, e.len);
      end
    end
    bus.iDmaEn = 1'b0;
    tick();
    n_run++;
    if ({bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy} !== 3'b000) begin
      n_fail++;
      $display("FAIL dis_withdraw: got %b exp 000",
        {bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy});
    end
    bus.iWrDmaDone  = 1'b1;
    bus.iRdDmaDone  = 1'b1;
    bus.iWrDmaAck   = 1'b1;
    bus.iRdDmaAck   = 1'b1;
    bus.iVsyncStart = 1'b1;
    tick();
    bus.iWrDmaDone  = 1'b0;
    bus.iRdDmaDone  = 1'b0;
    bus.iWrDmaAck   = 1'b0;
    bus.iRdDmaAck   = 1'b0;
    bus.iVsyncStart = 1'b0;
    n_run++;
    if ({bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy, bus.oFrameRepeat,
         bus.oRdOverrun, bus.oFrontSel} !== 6'b000001) begin
      n_fail++;
      $display("FAIL dis_stray: got %b exp 000001",
        {bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy, bus.oFrameRepeat,
         bus.oRdOverrun, bus.oFrontSel});
    end
    bus.iDmaEn = 1'b1;
    wr_q.push_back({A1, LEN});
    for (int k = 0; k < 8 && bus.oWrDmaReq !== 1'b1; k++) tick();
    n_run++;
    if (bus.oWrDmaReq !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_wr_req: got %b exp 1", bus.oWrDmaReq);
    end else begin
      e = wr_q.pop_front();
      n_run++;
      if ({bus.oWrDmaAdrs, bus.oWrDmaLen} !== e) begin
        n_fail++;
        $display("FAIL drain_wr_job: got %0d/%0d exp %0d/%0d",
          bus.oWrDmaAdrs, bus.oWrDmaLen, e.adrs, e.len);
      end
    end
    bus.iWrDmaAck = 1'b1;
    tick();
    bus.iWrDmaAck = 1'b0;
    bus.iDmaEn    = 1'b0;
    tick();
    n_run++;
    if (bus.oBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_busy: got %b exp 1", bus.oBusy);
    end
    bus.iWrDmaDone = 1'b1;
    tick();
    bus.iWrDmaDone = 1'b0;
    n_run++;
    if (bus.oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: got %b exp 0", bus.oBusy);
    end
    bus.iVsyncStart = 1'b1;
    exp_swaps++;
    tick();
    bus.iVsyncStart = 1'b0;
    tick();
    n_run++;
    if ({bus.oFrontSel, bus.oWrDmaReq, bus.oRdDmaReq,
         bus.oBusy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL drain_swap: got sel/wr/rd/busy %b exp 0000",
        {bus.oFrontSel, bus.oWrDmaReq, bus.oRdDmaReq, bus.oBusy});
    end
  endtask

  task automatic test_end();
    n_run++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues: got wr %0d rd %0d left exp 0 0",
        wr_q.size(), rd_q.size());
    end
`ifdef FBUF_SWAP_STAT_EN
    n_run++;
    if (int'(bus.oSwapCnt) != exp_swaps ||
        int'(bus.oRepeatCnt) != exp_reps) begin
      n_fail++;
      $display("FAIL stats: got %0d/%0d exp %0d/%0d",
        bus.oSwapCnt, bus.oRepeatCnt, exp_swaps, exp_reps);
    end
`endif
  endtask

  initial begin
    n_run           = 0;
    n_fail          = 0;
    exp_swaps       = 0;
    exp_reps        = 0;
    rst             = 1'b1;
    bus.iDmaEn      = 1'b0;
    bus.iFbufAdrs1  = '0;
    bus.iFbufAdrs2  = '0;
    bus.iFbufLen    = '0;
    bus.iVsyncStart = 1'b0;
    bus.iWrDmaAck   = 1'b0;
    bus.iWrDmaDone  = 1'b0;
    bus.iRdDmaAck   = 1'b0;
    bus.iRdDmaDone  = 1'b0;
    test_reset();
    test_first_write();
    test_swap();
    test_repeat();
    test_same_cycle();
    test_overrun();
    test_dma_disable();
    test_end();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
